// File: rtl/layer_output_serializer.sv
// Layer output serializer: captures the NN parallel neuron results of one layer
// into a capture bank, then streams them one word per cycle from a send bank so
// collection of the next frame overlaps streaming of the current one.
module layer_output_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  input  logic                    clr_overrun,
  output logic                    x_valid,
  output logic [dataWidth-1:0]    x_data,
  output logic                    x_last,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NN-1:0][dataWidth-1:0] r_cap;
  logic [NN-1:0][dataWidth-1:0] r_bank;
  logic [NN-1:0]                r_mask;
  logic [IW-1:0]                r_idx;
  logic                         r_x_valid;
  logic [dataWidth-1:0]         r_x_data;
  logic                         r_x_last;
  logic                         r_busy;
  logic                         r_overrun;

  logic [IW-1:0]                w_idx_nxt;
  logic [IW-1:0]                w_idx_inc;
  logic                         w_x_valid_nxt;
  logic [dataWidth-1:0]         w_x_data_nxt;
  logic                         w_full;
  logic                         w_at_last;
  logic                         w_xfer;
  logic [NN-1:0]                w_take;
  logic [NN-1:0]                w_mask_nxt;
  logic                         w_drop;

  // Transfer happens when the capture bank is complete and the sender is idle
  // or presenting its final word, so back-to-back frames have no bubble.
  assign w_full    = &r_mask;
  assign w_at_last = (r_idx == LAST_IDX);
  assign w_xfer    = w_full && ((r_state == ST_IDLE) || ((r_state == ST_SEND) && w_at_last));
  assign w_idx_inc = r_idx + {{(IW-1){1'b0}}, 1'b1};

  // A strobe is taken into an empty slot, or into any slot on a transfer edge
  // (that strobe belongs to the next frame); otherwise it is dropped.
  assign w_take     = i_valid & (w_xfer ? {NN{1'b1}} : ~r_mask);
  assign w_drop     = (|(i_valid & r_mask)) && !w_xfer;
  assign w_mask_nxt = (w_xfer ? {NN{1'b0}} : r_mask) | w_take;

  // Send FSM next-state and next serial-output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_x_valid_nxt = r_x_valid;
    w_x_data_nxt  = r_x_data;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_state_nxt   = ST_SEND;
          w_idx_nxt     = {IW{1'b0}};
          w_x_data_nxt  = r_cap[0];
          w_x_valid_nxt = 1'b1;
        end else begin
          w_x_valid_nxt = 1'b0;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          w_state_nxt   = ST_SEND;
          w_idx_nxt     = {IW{1'b0}};
          w_x_data_nxt  = r_cap[0];
          w_x_valid_nxt = 1'b1;
        end else if (w_at_last) begin
          w_state_nxt   = ST_IDLE;
          w_x_valid_nxt = 1'b0;
        end else begin
          w_idx_nxt     = w_idx_inc;
          w_x_data_nxt  = r_bank[w_idx_inc];
          w_x_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_idx_nxt     = {IW{1'b0}};
        w_x_valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM state, send index and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= {IW{1'b0}};
      r_x_valid <= 1'b0;
      r_x_data  <= {dataWidth{1'b0}};
      r_x_last  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_x_valid <= w_x_valid_nxt;
      r_x_data  <= w_x_data_nxt;
      r_x_last  <= (w_state_nxt == ST_SEND) && (w_idx_nxt == LAST_IDX);
      r_busy    <= (w_state_nxt == ST_SEND);
    end
  end

  // Capture bank, capture mask and send bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= {NN{1'b0}};
      r_cap  <= '0;
      r_bank <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      if (w_xfer) begin
        r_bank <= r_cap;
      end
      for (int k = 0; k < NN; k++) begin
        if (w_take[k]) begin
          r_cap[k] <= i_data[k*dataWidth +: dataWidth];
        end
      end
    end
  end

  // Sticky overrun flag; a new drop wins over a clear on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign x_valid = r_x_valid;
  assign x_data  = r_x_data;
  assign x_last  = r_x_last;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: directed frames on a 4-neuron instance and
// a randomized run on a 30-neuron instance checked against a word-queue model.
module tb_layer_output_serializer;

  localparam int DW  = 16;
  localparam int N4  = 4;
  localparam int N30 = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N4-1:0]     v4 = '0;
  logic [N4*DW-1:0]  d4 = '0;
  logic              clr4 = 1'b0;
  logic              xv4, xl4, busy4, ovr4;
  logic [DW-1:0]     xd4;

  logic [N30-1:0]    v30 = '0;
  logic [N30*DW-1:0] d30 = '0;
  logic              clr30 = 1'b0;
  logic              xv30, xl30, busy30, ovr30;
  logic [DW-1:0]     xd30;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  layer_output_serializer #(.NN(N4), .dataWidth(DW)) u_dut4 (
    .clk(clk), .rst(rst), .i_valid(v4), .i_data(d4), .clr_overrun(clr4),
    .x_valid(xv4), .x_data(xd4), .x_last(xl4), .busy(busy4), .overrun(ovr4)
  );

  layer_output_serializer #(.NN(N30), .dataWidth(DW)) u_dut30 (
    .clk(clk), .rst(rst), .i_valid(v30), .i_data(d30), .clr_overrun(clr30),
    .x_valid(xv30), .x_data(xd30), .x_last(xl30), .busy(busy30), .overrun(ovr30)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N4*DW-1:0] pack4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                             input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic drive4(input logic [N4-1:0] v, input logic [N4*DW-1:0] d);
    v4 = v;
    d4 = d;
  endtask

  // One edge, then the 4-neuron instance must be presenting word w.
  task automatic exp_word4(input string tag, input logic [DW-1:0] w, input logic last);
    tick();
    check_eq({tag, "_valid"}, {31'd0, xv4}, 32'd1);
    check_eq({tag, "_data"}, {16'd0, xd4}, {16'd0, w});
    check_eq({tag, "_last"}, {31'd0, xl4}, {31'd0, last});
  endtask

  task automatic exp_idle4(input string tag);
    check_eq({tag, "_valid"}, {31'd0, xv4}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy4}, 32'd0);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] m_cap[N30];
  bit            m_fill[N30];
  bit            m_ovr;

  initial begin
    word_t w;
    bit    full, xfer, drop;
    int    rate;

    // Reset state.
    rst = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", {31'd0, xv4}, 32'd0);
    check_eq("rst_data", {16'd0, xd4}, 32'd0);
    check_eq("rst_last", {31'd0, xl4}, 32'd0);
    check_eq("rst_busy", {31'd0, busy4}, 32'd0);
    check_eq("rst_ovr", {31'd0, ovr4}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: all strobes in one cycle.
    drive4(4'hF, pack4(16'd1, 16'd2, 16'd3, 16'd4));
    tick();
    drive4(4'h0, '0);
    check_eq("t1_e0_valid", {31'd0, xv4}, 32'd0);
    exp_word4("t1_w0", 16'd1, 1'b0);
    exp_word4("t1_w1", 16'd2, 1'b0);
    exp_word4("t1_w2", 16'd3, 1'b0);
    exp_word4("t1_w3", 16'd4, 1'b1);
    tick();
    exp_idle4("t1_end");
    check_eq("t1_ovr", {31'd0, ovr4}, 32'd0);

    // 2: staggered strobes, output ordered by neuron index.
    drive4(4'h1, pack4(16'd10, 16'd0, 16'd0, 16'd0));
    tick();
    drive4(4'h4, pack4(16'd0, 16'd0, 16'd30, 16'd0));
    tick();
    drive4(4'h0, '0);
    tick();
    drive4(4'hA, pack4(16'd0, 16'd20, 16'd0, 16'd40));
    tick();
    drive4(4'h0, '0);
    check_eq("t2_wait_valid", {31'd0, xv4}, 32'd0);
    exp_word4("t2_w0", 16'd10, 1'b0);
    exp_word4("t2_w1", 16'd20, 1'b0);
    exp_word4("t2_w2", 16'd30, 1'b0);
    exp_word4("t2_w3", 16'd40, 1'b1);
    tick();
    exp_idle4("t2_end");

    // 3: second frame collected during streaming -> no bubble.
    drive4(4'hF, pack4(16'd100, 16'd101, 16'd102, 16'd103));
    tick();
    drive4(4'h0, '0);
    exp_word4("t3_a0", 16'd100, 1'b0);
    drive4(4'hF, pack4(16'd200, 16'd201, 16'd202, 16'd203));
    exp_word4("t3_a1", 16'd101, 1'b0);
    drive4(4'h0, '0);
    exp_word4("t3_a2", 16'd102, 1'b0);
    exp_word4("t3_a3", 16'd103, 1'b1);
    exp_word4("t3_b0", 16'd200, 1'b0);
    exp_word4("t3_b1", 16'd201, 1'b0);
    exp_word4("t3_b2", 16'd202, 1'b0);
    exp_word4("t3_b3", 16'd203, 1'b1);
    tick();
    exp_idle4("t3_end");
    check_eq("t3_ovr", {31'd0, ovr4}, 32'd0);

    // 4: duplicate strobe on neuron 1 -> first value kept, overrun set then cleared.
    drive4(4'h2, pack4(16'd0, 16'd5, 16'd0, 16'd0));
    tick();
    drive4(4'h2, pack4(16'd0, 16'd9, 16'd0, 16'd0));
    tick();
    check_eq("t4_ovr_set", {31'd0, ovr4}, 32'd1);
    drive4(4'hD, pack4(16'd50, 16'd0, 16'd70, 16'd80));
    tick();
    drive4(4'h0, '0);
    exp_word4("t4_w0", 16'd50, 1'b0);
    exp_word4("t4_w1", 16'd5, 1'b0);
    exp_word4("t4_w2", 16'd70, 1'b0);
    exp_word4("t4_w3", 16'd80, 1'b1);
    tick();
    check_eq("t4_ovr_sticky", {31'd0, ovr4}, 32'd1);
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    check_eq("t4_ovr_clr", {31'd0, ovr4}, 32'd0);

    // 5: reset mid-frame abandons the frame and discards partial capture.
    drive4(4'hF, pack4(16'd11, 16'd12, 16'd13, 16'd14));
    tick();
    drive4(4'h1, pack4(16'd99, 16'd0, 16'd0, 16'd0));
    exp_word4("t5_w0", 16'd11, 1'b0);
    drive4(4'h0, '0);
    exp_word4("t5_w1", 16'd12, 1'b0);
    rst = 1'b0;
    tick();
    exp_idle4("t5_rst");
    check_eq("t5_rst_last", {31'd0, xl4}, 32'd0);
    rst = 1'b1;
    drive4(4'hE, pack4(16'd0, 16'd22, 16'd23, 16'd24));
    tick();
    drive4(4'h0, '0);
    tick();
    check_eq("t5_partial_valid", {31'd0, xv4}, 32'd0);
    drive4(4'h1, pack4(16'd21, 16'd0, 16'd0, 16'd0));
    tick();
    drive4(4'h0, '0);
    exp_word4("t5_n0", 16'd21, 1'b0);
    exp_word4("t5_n1", 16'd22, 1'b0);
    exp_word4("t5_n2", 16'd23, 1'b0);
    exp_word4("t5_n3", 16'd24, 1'b1);
    tick();
    exp_idle4("t5_end");

    // 6: random strobe timing on the 30-neuron instance against a queue model.
    // The queue holds the words still to be presented; its front is on x_data.
    for (int k = 0; k < N30; k++) begin
      m_fill[k] = 1'b0;
      m_cap[k]  = '0;
    end
    m_ovr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rate = ((c / 400) % 2 == 1) ? 2 : 12;
      for (int k = 0; k < N30; k++) begin
        v30[k] = ($urandom_range(0, rate) == 0);
        d30[k*DW +: DW] = DW'($urandom);
      end
      clr30 = ($urandom_range(0, 40) == 0);

      full = 1'b1;
      for (int k = 0; k < N30; k++) full = full && m_fill[k];
      xfer = full && (exp_q.size() <= 1);
      if (exp_q.size() > 0) w = exp_q.pop_front();
      if (xfer) begin
        for (int k = 0; k < N30; k++) begin
          w.d = m_cap[k];
          w.l = (k == N30 - 1);
          exp_q.push_back(w);
          m_fill[k] = 1'b0;
        end
      end
      drop = 1'b0;
      for (int k = 0; k < N30; k++) begin
        if (v30[k]) begin
          if (!m_fill[k]) begin
            m_cap[k]  = d30[k*DW +: DW];
            m_fill[k] = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      if (drop) m_ovr = 1'b1;
      else if (clr30) m_ovr = 1'b0;

      tick();
      check_eq("r_valid", {31'd0, xv30}, {31'd0, exp_q.size() > 0});
      check_eq("r_busy", {31'd0, busy30}, {31'd0, exp_q.size() > 0});
      check_eq("r_ovr", {31'd0, ovr30}, {31'd0, m_ovr});
      if (exp_q.size() > 0) begin
        check_eq("r_data", {16'd0, xd30}, {16'd0, exp_q[0].d});
        check_eq("r_last", {31'd0, xl30}, {31'd0, exp_q[0].l});
      end else begin
        check_eq("r_last_idle", {31'd0, xl30}, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
